// File: rtl/cpu_cmd_sequencer.sv
// Command sequencer for the vector CPU: buffers packed commands in a small FIFO
// and replays them one per cycle, holding loads to cover the memory read path.
module cpu_cmd_sequencer #(
  parameter int         DEPTH     = 4,
  parameter int         LOAD_HOLD = 2,
  parameter logic [2:0] IDLE_OP   = 3'b011
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [1:0]   cmd_reg,
  input  logic [8:0]   cmd_addr,
  input  logic [511:0] cmd_init,
  output logic [2:0]   instruction,
  output logic [1:0]   reg_addr,
  output logic [8:0]   mem_address,
  output logic [511:0] initialize_value,
  output logic         busy,
  output logic [15:0]  issued_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = (LOAD_HOLD > 1) ? $clog2(LOAD_HOLD) : 1;
  localparam int EW = 526;

  typedef enum logic {ISSUE, HOLD} state_t;

  state_t         r_state, w_nextState;
  logic [EW-1:0]  r_mem [DEPTH];
  logic [PW-1:0]  r_wrPtr, r_rdPtr;
  logic [CW-1:0]  r_count;
  logic [HW-1:0]  r_holdCnt, w_nextHoldCnt;
  logic           w_push, w_pop;
  logic [EW-1:0]  w_head;
  logic [2:0]     w_nextInstr;
  logic [1:0]     w_nextReg;
  logic [8:0]     w_nextAddr;
  logic [511:0]   w_nextInit;

  // Ready looks only at registered occupancy, so a full FIFO never refills in the pop cycle.
  assign cmd_ready = !rst && (r_count != CW'(DEPTH));
  assign w_push    = cmd_valid && cmd_ready;
  assign w_head    = r_mem[r_rdPtr];
  assign busy      = (r_count != '0) || (r_state == HOLD);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {cmd_op, cmd_reg, cmd_addr, cmd_init};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextHoldCnt = r_holdCnt;
    w_pop         = 1'b0;
    w_nextInstr   = instruction;
    w_nextReg     = reg_addr;
    w_nextAddr    = mem_address;
    w_nextInit    = initialize_value;
    case (r_state)
      ISSUE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_nextInstr = w_head[525:523];
          w_nextReg   = w_head[522:521];
          w_nextAddr  = w_head[520:512];
          w_nextInit  = w_head[511:0];
          if ((w_head[525:523] == 3'b000) && (LOAD_HOLD > 1)) begin
            w_nextState   = HOLD;
            w_nextHoldCnt = HW'(LOAD_HOLD - 1);
          end
        end else begin
          w_nextInstr = IDLE_OP;
          w_nextReg   = '0;
          w_nextAddr  = '0;
          w_nextInit  = '0;
        end
      end
      HOLD: begin
        w_nextHoldCnt = r_holdCnt - HW'(1);
        if (r_holdCnt <= HW'(1)) begin
          w_nextState = ISSUE;
        end
      end
      default: w_nextState = ISSUE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= ISSUE;
      r_holdCnt        <= '0;
      instruction      <= IDLE_OP;
      reg_addr         <= '0;
      mem_address      <= '0;
      initialize_value <= '0;
      issued_count     <= '0;
    end else begin
      r_state          <= w_nextState;
      r_holdCnt        <= w_nextHoldCnt;
      instruction      <= w_nextInstr;
      reg_addr         <= w_nextReg;
      mem_address      <= w_nextAddr;
      initialize_value <= w_nextInit;
      if (w_pop) issued_count <= issued_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_cpu_cmd_sequencer.sv
// Self-checking bench for cpu_cmd_sequencer: directed scenarios plus random traffic
// compared each cycle against a queue-based model of the command stream.
module tb_cpu_cmd_sequencer;

  localparam int         DEPTH     = 4;
  localparam int         LOAD_HOLD = 2;
  localparam logic [2:0] IDLE_OP   = 3'b011;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = '0;
  logic [1:0]   cmd_reg = '0;
  logic [8:0]   cmd_addr = '0;
  logic [511:0] cmd_init = '0;
  logic [2:0]   instruction;
  logic [1:0]   reg_addr;
  logic [8:0]   mem_address;
  logic [511:0] initialize_value;
  logic         busy;
  logic [15:0]  issued_count;

  typedef struct packed {
    logic [2:0]   op;
    logic [1:0]   rg;
    logic [8:0]   ad;
    logic [511:0] init;
  } cmd_t;

  cmd_t        q[$];
  cmd_t        outCmd;
  int          outLeft;
  logic [15:0] expIssued;
  int          testCount = 0;
  int          failCount = 0;

  cpu_cmd_sequencer #(.DEPTH(DEPTH), .LOAD_HOLD(LOAD_HOLD), .IDLE_OP(IDLE_OP)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_addr(cmd_addr), .cmd_init(cmd_init),
    .instruction(instruction), .reg_addr(reg_addr), .mem_address(mem_address),
    .initialize_value(initialize_value), .busy(busy), .issued_count(issued_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t idleCmd();
    cmd_t c;
    c = '0;
    c.op = IDLE_OP;
    return c;
  endfunction

  function automatic cmd_t mkCmd(input logic [2:0] op, input logic [1:0] rg,
                                 input logic [8:0] ad, input logic [511:0] init);
    cmd_t c;
    c.op = op; c.rg = rg; c.ad = ad; c.init = init;
    return c;
  endfunction

  task automatic modelReset();
    q.delete();
    outCmd    = idleCmd();
    outLeft   = 0;
    expIssued = '0;
  endtask

  // Each issued command owns the outputs for a fixed number of cycles; a new one
  // is taken from the queue only when the current one has used its last cycle.
  task automatic modelEdge(input logic v, input cmd_t c);
    logic pushOk;
    if (rst) return;
    pushOk = v && (q.size() != DEPTH);
    if (outLeft > 1) begin
      outLeft--;
    end else if (q.size() > 0) begin
      outCmd  = q.pop_front();
      outLeft = (outCmd.op == 3'b000) ? LOAD_HOLD : 1;
      expIssued++;
    end else begin
      outCmd  = idleCmd();
      outLeft = 0;
    end
    if (pushOk) q.push_back(c);
  endtask

  task automatic compareAll();
    logic expReady, expBusy;
    expReady = !rst && (q.size() != DEPTH);
    expBusy  = (q.size() != 0) || (outLeft > 1);
    checkOutput("instruction", 512'(instruction), 512'(outCmd.op));
    checkOutput("reg_addr", 512'(reg_addr), 512'(outCmd.rg));
    checkOutput("mem_address", 512'(mem_address), 512'(outCmd.ad));
    checkOutput("initialize_value", initialize_value, outCmd.init);
    checkOutput("cmd_ready", 512'(cmd_ready), 512'(expReady));
    checkOutput("busy", 512'(busy), 512'(expBusy));
    checkOutput("issued_count", 512'(issued_count), 512'(expIssued));
  endtask

  task automatic applyStimulus(input logic v, input cmd_t c);
    cmd_valid = v;
    cmd_op    = c.op;
    cmd_reg   = c.rg;
    cmd_addr  = c.ad;
    cmd_init  = c.init;
    @(posedge clk);
    modelEdge(v, c);
    @(negedge clk);
    compareAll();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, idleCmd());
  endtask

  task automatic pushCmd(input cmd_t c);
    logic acc;
    for (int i = 0; i < 20; i++) begin
      acc = !rst && (q.size() != DEPTH);
      applyStimulus(1'b1, c);
      if (acc) return;
    end
    testCount++;
    failCount++;
    $display("[TB] FAIL push_timeout: got not accepted expected accepted within 20 cycles");
  endtask

  // Reset is raised between clock edges so its asynchronous effect is visible at once.
  task automatic resetMid();
    #2 rst = 1'b1;
    #1 modelReset();
    compareAll();
    @(negedge clk);
    compareAll();
    rst = 1'b0;
    #1 compareAll();
  endtask

  cmd_t rc;

  initial begin
    modelReset();
    #1 rst = 1'b1;
    @(negedge clk);
    compareAll();
    rst = 1'b0;
    #1 compareAll();
    idleCycles(3);

    $display("[TB] single init");
    pushCmd(mkCmd(3'b100, 2'd2, 9'd0, {64{8'h5A}}));
    idleCycles(3);
    checkOutput("init_issued", 512'(issued_count), 512'(16'd1));

    $display("[TB] load then add");
    pushCmd(mkCmd(3'b000, 2'd1, 9'h1F3, '0));
    pushCmd(mkCmd(3'b010, 2'd3, 9'h044, '0));
    idleCycles(4);

    $display("[TB] fill FIFO behind load holds");
    for (int i = 0; i < 3; i++) pushCmd(mkCmd(3'b000, 2'(i), 9'(16 + i), '0));
    for (int i = 0; i < 5; i++) pushCmd(mkCmd(3'b001, 2'd0, 9'(i), '0));
    idleCycles(12);

    $display("[TB] streaming stores");
    for (int i = 0; i < 20; i++) pushCmd(mkCmd(3'b001, 2'(i), 9'(100 + i), '0));
    idleCycles(3);

    $display("[TB] reset during load hold");
    pushCmd(mkCmd(3'b000, 2'd1, 9'h010, '0));
    pushCmd(mkCmd(3'b000, 2'd2, 9'h011, '0));
    pushCmd(mkCmd(3'b010, 2'd3, 9'h012, '0));
    pushCmd(mkCmd(3'b011, 2'd0, 9'h013, '0));
    resetMid();
    idleCycles(6);
    checkOutput("post_reset_issued", 512'(issued_count), 512'(16'd0));

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      rc.op = 3'($urandom_range(0, 7));
      rc.rg = 2'($urandom_range(0, 3));
      rc.ad = 9'($urandom_range(0, 511));
      for (int w = 0; w < 16; w++) rc.init[w*32 +: 32] = $urandom();
      applyStimulus($urandom_range(0, 9) < 7, rc);
      if (n == 200) resetMid();
    end
    idleCycles(10);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
